// File: rtl/mic_pkg.sv
// Shared types and saturation helpers for the mic level meter datapath.
package mic_pkg;

  localparam int DEFAULT_SAMPLE_DEPTH = 16;

  // Clamp a sign-extended value into the signed range of 'width' bits.
  function automatic logic signed [31:0] sat_signed(input logic signed [31:0] value,
                                                    input int width);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (width - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (width - 1));
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

  // Magnitude with the most negative code folded onto the largest positive one.
  function automatic logic [31:0] abs_sat(input logic signed [31:0] value, input int width);
    logic signed [31:0] hi;
    logic signed [31:0] m;
    hi = (32'sd1 <<< (width - 1)) - 32'sd1;
    m  = (value < 0) ? -value : value;
    if (m > hi) m = hi;
    return m;
  endfunction

endpackage

// File: rtl/mic_level_meter_if.sv
// Decimated sample stream between the level meter and its consumer.
interface mic_level_meter_if #(
  parameter int SD = 16
);
  logic signed [SD-1:0] sample_out;
  logic                 sample_valid;
  logic                 sample_ready;

  modport master (output sample_out, output sample_valid, input sample_ready);
  modport slave  (input sample_out, input sample_valid, output sample_ready);
endinterface

// File: rtl/dc_blocker.sv
// First-order DC tracker: y = x - (acc >>> DC_SHIFT), acc integrates y before saturation.
// One cycle from en to y_valid; acc only moves on en.
module dc_blocker
  import mic_pkg::*;
#(
  parameter int SD       = DEFAULT_SAMPLE_DEPTH,
  parameter int DC_SHIFT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [SD-1:0] x,
  input  logic                 en,
  output logic signed [SD-1:0] y,
  output logic                 y_valid
);

  localparam int AW = SD + DC_SHIFT + 1;

  logic signed [AW-1:0] acc_q, acc_d;
  logic signed [SD-1:0] y_q, y_d;
  logic                 y_vld_q, y_vld_d;
  logic signed [SD:0]   dc;
  logic signed [SD:0]   hp;

  always_comb begin
    dc      = (SD+1)'(acc_q >>> DC_SHIFT);
    hp      = $signed({x[SD-1], x}) - dc;
    acc_d   = acc_q;
    y_d     = y_q;
    y_vld_d = en;
    if (en) begin
      // acc is wide enough to never wrap, so it integrates the unsaturated difference
      acc_d = acc_q + AW'(hp);
      y_d   = SD'(sat_signed(32'(hp), SD));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q   <= '0;
      y_q     <= '0;
      y_vld_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      y_q     <= y_d;
      y_vld_q <= y_vld_d;
    end
  end

  assign y       = y_q;
  assign y_valid = y_vld_q;

endmodule

// File: rtl/mic_level_meter.sv
// Decimates audio_in, removes DC, streams samples on valid/ready and drives a decaying peak level.
// A new sample overwrites an unaccepted one and bumps the saturating dropped count.
module mic_level_meter
  import mic_pkg::*;
#(
  parameter int SAMPLE_DEPTH = DEFAULT_SAMPLE_DEPTH,
  parameter int DECIMATE     = 256,
  parameter int DC_SHIFT     = 8,
  parameter int DECAY_SHIFT  = 4,
  parameter int LEVEL_BITS   = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic signed [SAMPLE_DEPTH-1:0] audio_in,
  mic_level_meter_if.master              smp,
  output logic [LEVEL_BITS-1:0]          level,
  output logic [7:0]                     dropped
);

  localparam int CW = $clog2(DECIMATE);
  localparam int MW = SAMPLE_DEPTH - 1;

  logic [CW-1:0]                  cnt_q, cnt_d;
  logic                           tick;
  logic signed [SAMPLE_DEPTH-1:0] x_q, x_d;
  logic                           x_vld_q, x_vld_d;
  logic signed [SAMPLE_DEPTH-1:0] y;
  logic                           y_valid;
  logic signed [SAMPLE_DEPTH-1:0] out_q, out_d;
  logic                           vld_q, vld_d;
  logic [MW-1:0]                  mag_q, mag_d;
  logic                           mag_vld_q, mag_vld_d;
  logic [MW-1:0]                  peak_q, peak_d;
  logic [MW-1:0]                  decayed;
  logic [7:0]                     drop_q, drop_d;

  dc_blocker #(
    .SD       (SAMPLE_DEPTH),
    .DC_SHIFT (DC_SHIFT)
  ) u_dc_blocker (
    .clk     (clk),
    .rst     (rst),
    .x       (x_q),
    .en      (x_vld_q),
    .y       (y),
    .y_valid (y_valid)
  );

  always_comb begin
    tick      = (cnt_q == CW'(DECIMATE - 1));
    cnt_d     = tick ? '0 : cnt_q + 1'b1;
    x_d       = tick ? audio_in : x_q;
    x_vld_d   = tick;

    out_d     = y_valid ? y : out_q;
    vld_d     = vld_q & ~smp.sample_ready;
    if (y_valid) vld_d = 1'b1;

    // Overwrite only counts as a drop if the held sample is not leaving this same edge
    drop_d    = drop_q;
    if (y_valid && vld_q && !smp.sample_ready && drop_q != 8'hFF) drop_d = drop_q + 8'd1;

    mag_d     = y_valid ? MW'(abs_sat(32'(y), SAMPLE_DEPTH)) : mag_q;
    mag_vld_d = y_valid;

    decayed   = peak_q - (peak_q >> DECAY_SHIFT);
    peak_d    = peak_q;
    if (mag_vld_q) peak_d = (mag_q > decayed) ? mag_q : decayed;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      x_q       <= '0;
      x_vld_q   <= 1'b0;
      out_q     <= '0;
      vld_q     <= 1'b0;
      mag_q     <= '0;
      mag_vld_q <= 1'b0;
      peak_q    <= '0;
      drop_q    <= '0;
    end else begin
      cnt_q     <= cnt_d;
      x_q       <= x_d;
      x_vld_q   <= x_vld_d;
      out_q     <= out_d;
      vld_q     <= vld_d;
      mag_q     <= mag_d;
      mag_vld_q <= mag_vld_d;
      peak_q    <= peak_d;
      drop_q    <= drop_d;
    end
  end

  assign smp.sample_out   = out_q;
  assign smp.sample_valid = vld_q;
  assign level            = peak_q[SAMPLE_DEPTH-2 -: LEVEL_BITS];
  assign dropped          = drop_q;

endmodule

// File: tb/tb_mic_level_meter.sv
// Directed bench for mic_level_meter with DECIMATE=4, DC_SHIFT=2, DECAY_SHIFT=1.
module tb_mic_level_meter;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [15:0] audio_in;
  logic [7:0]         level;
  logic [7:0]         dropped;
  int                 checks   = 0;
  int                 failures = 0;

  mic_level_meter_if #(.SD(16)) sif ();

  mic_level_meter #(
    .SAMPLE_DEPTH (16),
    .DECIMATE     (4),
    .DC_SHIFT     (2),
    .DECAY_SHIFT  (1),
    .LEVEL_BITS   (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .audio_in (audio_in),
    .smp      (sif),
    .level    (level),
    .dropped  (dropped)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic get_sample(input string tag, output logic signed [15:0] s);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sif.sample_valid && n < 16);
    check({tag, "_valid_seen"}, 32'(sif.sample_valid), 1);
    s = sif.sample_out;
  endtask

  initial begin
    logic signed [15:0] s;
    logic signed [15:0] ys[22];
    int                 n;

    rst              = 1'b1;
    audio_in         = '0;
    sif.sample_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_sample_out", sif.sample_out, 0);
    check("rst_valid", 32'(sif.sample_valid), 0);
    check("rst_level", 32'(level), 0);
    check("rst_dropped", 32'(dropped), 0);

    // Constant 1000: DC tracker pulls the output toward zero
    audio_in         = 16'sd1000;
    sif.sample_ready = 1'b1;
    rst              = 1'b0;
    for (int i = 0; i < 22; i++) get_sample("dc1000", ys[i]);
    check("dc1000_y1", ys[0], 1000);
    check("dc1000_y2", ys[1], 750);
    check("dc1000_y3", ys[2], 563);
    check("dc1000_y4", ys[3], 422);
    check("dc1000_y20", ys[19], 4);
    check("dc1000_y21", ys[20], 3);
    check("dc1000_dropped", 32'(dropped), 0);

    // Full-scale negative input saturates the magnitude
    audio_in = -16'sd32768;
    do_reset();
    get_sample("neg", s);
    check("neg_y1", s, -32768);
    @(negedge clk);
    check("neg_level1", 32'(level), 255);
    get_sample("neg", s);
    check("neg_y2", s, -24576);
    @(negedge clk);
    check("neg_level2", 32'(level), 192);

    // Single-tick impulse, then silence: level halves and eventually hits 0
    audio_in = 16'sd16384;
    do_reset();
    repeat (4) @(negedge clk);
    audio_in = '0;
    get_sample("imp", s);
    check("imp_y1", s, 16384);
    @(negedge clk);
    check("imp_level1", 32'(level), 128);
    get_sample("imp", s);
    check("imp_y2", s, -4096);
    @(negedge clk);
    check("imp_level2", 32'(level), 64);
    get_sample("imp", s);
    check("imp_y3", s, -3072);
    @(negedge clk);
    check("imp_level3", 32'(level), 32);
    for (int i = 0; i < 60 && level != 8'd0; i++) begin
      get_sample("imp_tail", s);
      @(negedge clk);
    end
    check("imp_level_zero", 32'(level), 0);

    // Consumer stalls for three sample periods
    audio_in         = 16'sd1000;
    sif.sample_ready = 1'b0;
    do_reset();
    get_sample("stall", s);
    check("stall_first", s, 1000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_hold_data", sif.sample_out, 1000);
      check("stall_hold_valid", 32'(sif.sample_valid), 1);
    end
    repeat (5) @(negedge clk);
    check("stall_latest", sif.sample_out, 563);
    check("stall_valid", 32'(sif.sample_valid), 1);
    check("stall_dropped", 32'(dropped), 2);
    sif.sample_ready = 1'b1;
    @(negedge clk);
    check("drain_valid", 32'(sif.sample_valid), 0);
    check("drain_dropped", 32'(dropped), 2);

    // Accept and reload on the same edge
    sif.sample_ready = 1'b0;
    repeat (6) @(negedge clk);
    check("same_edge_old", sif.sample_out, 422);
    check("same_edge_old_valid", 32'(sif.sample_valid), 1);
    sif.sample_ready = 1'b1;
    @(negedge clk);
    check("same_edge_valid", 32'(sif.sample_valid), 1);
    check("same_edge_new", sif.sample_out, 317);
    check("same_edge_dropped", 32'(dropped), 2);
    @(negedge clk);
    check("same_edge_valid_drop", 32'(sif.sample_valid), 0);

    // Asynchronous reset between edges
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_sample_out", sif.sample_out, 0);
    check("arst_valid", 32'(sif.sample_valid), 0);
    check("arst_level", 32'(level), 0);
    check("arst_dropped", 32'(dropped), 0);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sif.sample_valid && n < 20);
    check("arst_first_valid_cycles", n, 6);
    check("arst_first_sample", sif.sample_out, 1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
